// File: rtl/panel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : panel_pkg
// Purpose  : Shared definitions for the front-panel input block: lamp count,
//            default timing parameters and the mode-button FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package panel_pkg;

  localparam int NUM_LAMPS                 = 6;
  localparam int DEFAULT_DEBOUNCE_CYCLES   = 100000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 20000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    HELD   = 2'd2
  } mode_state_t;

endpackage
`default_nettype wire

// File: rtl/panel_input_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module   : debounce_bit
// Purpose  : 2-flop synchroniser followed by a debounce counter. The stable
//            level only follows the synced level after it has differed for
//            DEBOUNCE_CYCLES consecutive cycles.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_bit
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_level,
  output logic stable_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw_level;
      sync_q2 <= sync_q1;
    end
  end

  // Accept the synced level once it has differed for the full debounce window;
  // any cycle of agreement restarts the window.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt          <= '0;
      stable_level <= 1'b0;
    end else if (sync_q2 != stable_level) begin
      if (cnt == CNT_LAST) begin
        stable_level <= sync_q2;
        cnt          <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/panel_input.sv
`default_nettype none
// ============================================================================
// Module   : panel_input
// Purpose  : Front-panel input block. Debounces six lamp buttons and a mode
//            button; lamp presses toggle led_enable bits, a long mode press
//            toggles mtne_mode and a short mode press clears led_enable.
//            Optional macro PANEL_MTNE_LOCKOUT_EN freezes led_enable while
//            mtne_mode is set.
// Revision : 1.0 - initial release
// ============================================================================
module panel_input
  import panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_LAMPS-1:0] button_in,
  input  logic                 mode_button_in,
  output logic [NUM_LAMPS-1:0] led_enable,
  output logic                 mtne_mode,
  output logic [NUM_LAMPS-1:0] press_event
);

  localparam int LP_W = $clog2(LONG_PRESS_CYCLES);
  // The toggle edge is the one on which the counter steps to its last value.
  localparam logic [LP_W-1:0] LP_PENULT = LP_W'(LONG_PRESS_CYCLES - 2);

  logic [NUM_LAMPS-1:0] lamp_stable;
  logic [NUM_LAMPS-1:0] lamp_prev;
  logic [NUM_LAMPS-1:0] lamp_rise;
  logic [NUM_LAMPS-1:0] lamp_toggle;
  logic                 mode_stable;
  logic                 mode_prev;
  logic                 mode_rise;
  logic                 lockout;
  mode_state_t          state;
  logic [LP_W-1:0]      lp_cnt;

  generate
    for (genvar i = 0; i < NUM_LAMPS; i++) begin : g_lamp
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_lamp_db (
        .clock       (clock),
        .reset       (reset),
        .raw_level   (button_in[i]),
        .stable_level(lamp_stable[i])
      );
    end
  endgenerate

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_mode_db (
    .clock       (clock),
    .reset       (reset),
    .raw_level   (mode_button_in),
    .stable_level(mode_stable)
  );

`ifdef PANEL_MTNE_LOCKOUT_EN
  assign lockout = mtne_mode;
`else
  assign lockout = 1'b0;
`endif

  assign lamp_rise   = lamp_stable & ~lamp_prev;
  assign mode_rise   = mode_stable & ~mode_prev;
  assign lamp_toggle = lockout ? '0 : lamp_rise;

  // Edge-detect history and the one-cycle press pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      lamp_prev   <= '0;
      mode_prev   <= 1'b0;
      press_event <= '0;
    end else begin
      lamp_prev   <= lamp_stable;
      mode_prev   <= mode_stable;
      press_event <= lamp_rise;
    end
  end

  // Mode FSM plus the lamp word; the short-press clear is written last so it
  // overrides any lamp toggle landing on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      lp_cnt     <= '0;
      mtne_mode  <= 1'b0;
      led_enable <= '0;
    end else begin
      led_enable <= led_enable ^ lamp_toggle;
      case (state)
        IDLE: begin
          if (mode_rise) begin
            state  <= TIMING;
            lp_cnt <= '0;
          end
        end
        TIMING: begin
          if (!mode_stable) begin
            state <= IDLE;
            if (!lockout) begin
              led_enable <= '0;
            end
          end else if (lp_cnt == LP_PENULT) begin
            lp_cnt    <= lp_cnt + 1'b1;
            mtne_mode <= ~mtne_mode;
            state     <= HELD;
          end else begin
            lp_cnt <= lp_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!mode_stable) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_panel_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_panel_input
// Purpose  : Directed self-checking bench for panel_input with
//            DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=16. Lamp presses come
//            from a vector table; reset, bounce, short, long and lockout
//            scenarios are hand-written sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_panel_input;

  logic       clock;
  logic       reset;
  logic [5:0] button_in;
  logic       mode_button_in;
  logic [5:0] led_enable;
  logic       mtne_mode;
  logic [5:0] press_event;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [5:0] btn;
    logic [5:0] exp_led;
    logic [5:0] exp_pe;
  } vec_t;

  vec_t vecs[7];

  panel_input #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button_in     (button_in),
    .mode_button_in(mode_button_in),
    .led_enable    (led_enable),
    .mtne_mode     (mtne_mode),
    .press_event   (press_event)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_led"}, led_enable, 6'b0);
    check({name, "_mtne"}, {5'b0, mtne_mode}, 6'b0);
    check({name, "_pe"}, press_event, 6'b0);
  endtask

  // Raw press held from edge N: pulse and toggle at N+6, silent at N+5/N+7.
  task automatic apply_vec(input vec_t v, input string name);
    button_in = v.btn;
    step(6);
    check({name, "_pe_early"}, press_event, 6'b0);
    step(1);
    check({name, "_led"}, led_enable, v.exp_led);
    check({name, "_pe"}, press_event, v.exp_pe);
    step(1);
    check({name, "_pe_after"}, press_event, 6'b0);
    button_in = 6'b0;
    step(10);
    check({name, "_led_release"}, led_enable, v.exp_led);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    reset          = 1'b1;
    button_in      = 6'b111111;
    mode_button_in = 1'b1;

    vecs[0] = '{btn: 6'b000100, exp_led: 6'b000100, exp_pe: 6'b000100};
    vecs[1] = '{btn: 6'b000100, exp_led: 6'b000000, exp_pe: 6'b000100};
    vecs[2] = '{btn: 6'b101001, exp_led: 6'b101001, exp_pe: 6'b101001};
    vecs[3] = '{btn: 6'b000100, exp_led: 6'b101101, exp_pe: 6'b000100};
    vecs[4] = '{btn: 6'b111111, exp_led: 6'b010010, exp_pe: 6'b111111};
    vecs[5] = '{btn: 6'b010010, exp_led: 6'b000000, exp_pe: 6'b010010};
    vecs[6] = '{btn: 6'b101101, exp_led: 6'b101101, exp_pe: 6'b101101};

    // Reset held 3 cycles with every input high, then 6 quiet cycles.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_all_zero("in_reset");
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check_all_zero("post_reset");
    end

    // Clean restart with inputs idle.
    button_in      = 6'b0;
    mode_button_in = 1'b0;
    reset          = 1'b1;
    step(2);
    reset = 1'b0;
    step(10);
    check_all_zero("idle");

    // Bounce: 2-cycle pulses on button 0 must never be accepted.
    for (int i = 0; i < 5; i++) begin
      button_in[0] = 1'b1;
      step(1); check("bounce_pe", press_event, 6'b0);
      step(1); check("bounce_pe", press_event, 6'b0);
      button_in[0] = 1'b0;
      step(1); check("bounce_pe", press_event, 6'b0);
      step(1); check("bounce_pe", press_event, 6'b0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("bounce_tail_pe", press_event, 6'b0);
    end
    check("bounce_led", led_enable, 6'b0);

    // Lamp toggles from the table; leaves led_enable = 101101.
    for (int i = 0; i < 7; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Short press: raw high for edges N..N+7, stable fall at N+13, clear at N+14.
    mode_button_in = 1'b1;
    step(8);
    mode_button_in = 1'b0;
    step(6);
    check("short_led_before", led_enable, 6'b101101);
    step(1);
    check("short_led_clear", led_enable, 6'b0);
    check("short_mtne", {5'b0, mtne_mode}, 6'b0);
    step(10);

    // Light lamp 1 so the long press has something to leave alone.
    apply_vec('{btn: 6'b000010, exp_led: 6'b000010, exp_pe: 6'b000010}, "pre_long");

    // Long press: stable rise at N+5, toggle 16 edges later at N+21.
    mode_button_in = 1'b1;
    step(21);
    check("long_mtne_before", {5'b0, mtne_mode}, 6'b0);
    step(1);
    check("long_mtne_toggle", {5'b0, mtne_mode}, 6'b000001);
    step(8);
    mode_button_in = 1'b0;
    step(15);
    check("long_mtne_after", {5'b0, mtne_mode}, 6'b000001);
    check("long_led_kept", led_enable, 6'b000010);

    // Lamp 5 press while in maintenance mode.
`ifdef PANEL_MTNE_LOCKOUT_EN
    apply_vec('{btn: 6'b100000, exp_led: 6'b000010, exp_pe: 6'b100000}, "lockout");
`else
    apply_vec('{btn: 6'b100000, exp_led: 6'b100010, exp_pe: 6'b100000}, "lockout");
`endif

    // Reset from a non-zero state clears everything.
    reset = 1'b1;
    step(1);
    check_all_zero("final_reset");
    reset = 1'b0;
    step(3);
    check_all_zero("final_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/panel_input.md
# panel_input

Front-panel input block that turns raw push-button levels into the LED-lamp control word and the maintenance-mode flag. It synchronises and debounces six lamp buttons plus one mode button. Each lamp-button press toggles its bit of `led_enable`. The mode button is timed: a long press toggles `mtne_mode`, and a short press clears every lamp enable. It sits between the board pins and the LED sequencer, driving that block's `led_enable` and `mtne_mode` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: number of consecutive clock cycles an input must hold a new level before it is accepted. Minimum 2.
- `LONG_PRESS_CYCLES`, default 20000000: number of cycles the debounced mode button must stay high for the press to count as long. Minimum 2, and must be greater than `DEBOUNCE_CYCLES`.
- `clock`  input  1: system clock; all state is updated on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `button_in`  input  6: raw lamp buttons, active-high, asynchronous to `clock`, may bounce.
- `mode_button_in`  input  1: raw mode button, active-high, asynchronous, may bounce.
- `led_enable`  output  6: registered lamp enable word.
- `mtne_mode`  output  1: registered maintenance-mode flag.
- `press_event`  output  6: one-cycle pulse per accepted lamp-button press.

## Operation
- **Reset.** While `reset` is high at a clock edge, the following are all cleared to 0:
  - `led_enable` = 0, `mtne_mode` = 0, `press_event` = 0;
  - all synchroniser stages, debounce counters and stable levels;
  - the mode FSM, which returns to IDLE.
- **Reset mid-press.** Any press in progress when reset asserts is discarded. A button still held after reset releases is accepted as a new press only once it has been debounced again.
- **Synchronisation and debounce.** Every raw input passes through a 2-flop synchroniser and then a per-bit debounce counter.
  - The counter increments while the synced level differs from the stable level.
  - When it reaches `DEBOUNCE_CYCLES`-1 with the levels still differing, the stable level takes the synced value and the counter clears.
  - Any cycle in which the two levels are equal also clears the counter.
- **Lamp press.** A rising edge on a stable lamp bit does two things on the next edge:
  - inverts the matching `led_enable` bit;
  - pulses the matching `press_event` bit for one cycle.
- **Stable falling edges** have no effect.
- **Mode FSM states.**
  - IDLE: on a stable mode-button rise, go to TIMING and clear the long-press counter.
  - TIMING: the counter increments each cycle.
    - If the button releases first, this is a short press: go to IDLE and clear `led_enable` to 0.
    - If the counter reaches `LONG_PRESS_CYCLES`-1 with the button still high, this is a long press: invert `mtne_mode` and go to HELD.
  - HELD: on release, go to IDLE with no further action.
- **Simultaneous events.**
  - A short-press clear and a lamp toggle in the same cycle: the clear wins and `led_enable` = 0. `press_event` still pulses.
  - Several lamp buttons may toggle in the same cycle, each independently.
- **Widths.** Counter widths are `$clog2` of the corresponding parameter. Counters never wrap: they saturate by construction because they clear at their terminal count.

## Timing
- **Lamp-button latency.** A raw change that is held steady is first sampled at edge N. Then:
  - the synced level changes at edge N+1;
  - the stable level changes at edge N+1+`DEBOUNCE_CYCLES`;
  - `led_enable` and `press_event` update at edge N+2+`DEBOUNCE_CYCLES`.
- **Glitch rejection.** A glitch shorter than `DEBOUNCE_CYCLES` synced cycles never changes the stable level.
- **Long press.** `mtne_mode` toggles `LONG_PRESS_CYCLES` edges after the stable mode rise.
- **Short press.** The `led_enable` clear lands 1 edge after the stable mode fall.
- **Registered outputs.** All outputs are registered; none has a combinational path from any input.

## Configuration
- Macro: `PANEL_MTNE_LOCKOUT_EN`.
- **Defined:**
  - while `mtne_mode` = 1, lamp presses and short-press clears leave `led_enable` unchanged;
  - `press_event` still pulses;
  - long press still toggles `mtne_mode`.
- **Undefined:** lamp toggles and short-press clears act regardless of `mtne_mode`.

## Structure
- **Shared package `panel_pkg`:**
  - mode FSM state enum (IDLE, TIMING, HELD);
  - lamp count constant `NUM_LAMPS` = 6;
  - default values for both parameters.
- **Sub-module `debounce_bit`:** synchroniser plus debounce counter, parameterised by `DEBOUNCE_CYCLES`, outputting the stable level. It is instantiated 7 times (6 lamp buttons plus the mode button). Edge detection and the FSM live in `panel_input`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=16.
- **Reset:** drive all inputs high and hold `reset` for 3 cycles -> all outputs are 0 during reset and for at least 6 cycles after it releases.
- **Lamp toggle:** raise `button_in[2]` at edge N and hold it -> `led_enable` = 000100 and `press_event[2]` pulses at edge N+6. Release it, then press again -> `led_enable` returns to 0.
- **Bounce rejection:** toggle `button_in[0]` every 2 cycles for 20 cycles and then drop it low -> `led_enable` = 0 and `press_event` never pulses.
- **Long press:** hold `mode_button_in` for 30 cycles -> `mtne_mode` goes 0 to 1 exactly 16 edges after the stable rise. Release it -> `led_enable` is unchanged.
- **Short press:** set `led_enable` = 101101, then hold the mode button for 8 cycles -> `led_enable` = 0 one edge after the stable fall, and `mtne_mode` is unchanged.
- **Lockout:** with `PANEL_MTNE_LOCKOUT_EN` defined and `mtne_mode` = 1, press `button_in[5]` -> `press_event[5]` pulses and `led_enable` stays unchanged. With the macro undefined -> `led_enable[5]` toggles.
